writeback_stage: RTL and testbench

- MEM/WB pipeline register plus writeback select for the 16-bit RISC core.
- Sits directly upstream of the 16-entry register file and drives its write port (destination register, data, write enable).
- Provides write-through bypass on the decode-stage read ports, so a same-cycle read of the register being written returns the new value.
- Tracks halt retirement and counts retired instructions.

---
 rtl/core_pkg.sv | 15 +
 rtl/writeback_stage_if.sv | 23 ++
 rtl/wb_src_bypass.sv | 16 +
 rtl/writeback_stage.sv | 120 ++++++++++++
 tb/tb_writeback_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit RISC core: datapath widths, writeback
// source encoding and the hardwired-zero register index.
package core_pkg;
  localparam int DATA_W       = 16;
  localparam int REG_AW       = 4;
  localparam int NUM_RD_PORTS = 2;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC2  = 2'b10
  } wb_sel_e;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB instruction bus; the MEM stage is the master, writeback the slave.
interface writeback_stage_if #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
);
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [DATA_W-1:0] mem_pc_plus2;
  logic [REG_AW-1:0] mem_dst_reg;
  logic              mem_reg_write;
  logic [1:0]        mem_wb_sel;
  logic              mem_halt;

  modport master (
    output mem_valid, mem_alu_result, mem_load_data, mem_pc_plus2,
           mem_dst_reg, mem_reg_write, mem_wb_sel, mem_halt
  );
  modport slave (
    input  mem_valid, mem_alu_result, mem_load_data, mem_pc_plus2,
           mem_dst_reg, mem_reg_write, mem_wb_sel, mem_halt
  );
endinterface

// File: rtl/wb_src_bypass.sv
// Write-through forwarding for one decode read port: a read of the register
// being written this cycle sees the new value instead of the stale RF data.
module wb_src_bypass #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_reg,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] rd_data
);
  // wr_en is never high for R0, so R0 reads always come from the RF.
  assign rd_data = (wr_en && (rd_reg == wr_reg)) ? wr_data : rf_data;
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback select, RF write port with decode-side
// bypass, halt retirement and a saturating retired-instruction counter.
module writeback_stage
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_stage_if.slave    mem,
  input  logic                stall,
  input  logic                flush,
  input  logic [REG_AW-1:0]   id_src_reg1,
  input  logic [REG_AW-1:0]   id_src_reg2,
  input  logic [DATA_W-1:0]   rf_src_data1,
  input  logic [DATA_W-1:0]   rf_src_data2,
  output logic [REG_AW-1:0]   wb_dst_reg,
  output logic [DATA_W-1:0]   wb_dst_data,
  output logic                wb_write_reg,
  output logic [DATA_W-1:0]   id_src_data1,
  output logic [DATA_W-1:0]   id_src_data2,
  output logic                halted,
  output logic [15:0]         retired_count
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] load;
    logic [DATA_W-1:0] pc2;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic [1:0]        sel;
    logic              halt;
  } wb_req_t;

  wb_req_t     wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        committed_q, committed_d;
  logic        halted_q, halted_d;
  logic [15:0] retired_count_q, retired_count_d;
  logic        retire, halt_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q            <= '0;
      wb_valid_q      <= 1'b0;
      committed_q     <= 1'b0;
      halted_q        <= 1'b0;
      retired_count_q <= '0;
    end else begin
      wb_q            <= wb_d;
      wb_valid_q      <= wb_valid_d;
      committed_q     <= committed_d;
      halted_q        <= halted_d;
      retired_count_q <= retired_count_d;
    end
  end

  always_comb begin
    retire          = wb_valid_q & ~committed_q;
    // A retiring HLT already blocks the instruction behind it at the same edge.
    halt_now        = halted_q | (retire & wb_q.halt);
    wb_d            = wb_q;
    wb_valid_d      = wb_valid_q;
    committed_d     = committed_q;
    halted_d        = halt_now;
    retired_count_d = retired_count_q;
    if (retire && (retired_count_q != 16'hFFFF))
      retired_count_d = retired_count_q + 16'd1;

    if (flush || halt_now) begin
      wb_valid_d  = 1'b0;
      committed_d = 1'b0;
    end else if (stall) begin
      committed_d = committed_q | wb_valid_q;
    end else begin
      wb_d.alu       = mem.mem_alu_result;
      wb_d.load      = mem.mem_load_data;
      wb_d.pc2       = mem.mem_pc_plus2;
      wb_d.dst       = mem.mem_dst_reg;
      wb_d.reg_write = mem.mem_reg_write;
      wb_d.sel       = mem.mem_wb_sel;
      wb_d.halt      = mem.mem_halt;
      wb_valid_d     = mem.mem_valid;
      committed_d    = 1'b0;
    end
  end

  always_comb begin
    case (wb_q.sel)
      WB_LOAD: wb_dst_data = wb_q.load;
      WB_PC2:  wb_dst_data = wb_q.pc2;
      default: wb_dst_data = wb_q.alu;
    endcase
  end

  assign wb_dst_reg    = wb_q.dst;
  assign wb_write_reg  = wb_valid_q & wb_q.reg_write & (wb_q.dst != REG_ZERO) & ~committed_q;
  assign halted        = halted_q;
  assign retired_count = retired_count_q;

  logic [NUM_RD_PORTS-1:0][REG_AW-1:0] rd_reg;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_rf, rd_id;

  assign rd_reg = {id_src_reg2, id_src_reg1};
  assign rd_rf  = {rf_src_data2, rf_src_data1};
  assign id_src_data1 = rd_id[0];
  assign id_src_data2 = rd_id[1];

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_byp
    wb_src_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp (
      .wr_en   (wb_write_reg),
      .wr_reg  (wb_q.dst),
      .wr_data (wb_dst_data),
      .rd_reg  (rd_reg[g]),
      .rf_data (rd_rf[g]),
      .rd_data (rd_id[g])
    );
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized bench for writeback_stage with an instruction-level
// reference model and a register-file model feeding the RF read data inputs.
module tb_writeback_stage;
  import core_pkg::*;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if #(.DATA_W(DW), .REG_AW(AW)) mem_if ();
  logic          stall, flush;
  logic [AW-1:0] id_src_reg1, id_src_reg2;
  logic [DW-1:0] rf_src_data1, rf_src_data2;
  logic [AW-1:0] wb_dst_reg;
  logic [DW-1:0] wb_dst_data, id_src_data1, id_src_data2;
  logic          wb_write_reg, halted;
  logic [15:0]   retired_count;

  writeback_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mem_if),
    .stall(stall), .flush(flush),
    .id_src_reg1(id_src_reg1), .id_src_reg2(id_src_reg2),
    .rf_src_data1(rf_src_data1), .rf_src_data2(rf_src_data2),
    .wb_dst_reg(wb_dst_reg), .wb_dst_data(wb_dst_data), .wb_write_reg(wb_write_reg),
    .id_src_data1(id_src_data1), .id_src_data2(id_src_data2),
    .halted(halted), .retired_count(retired_count)
  );

  // Register file model: written with whatever the model says retires.
  logic [DW-1:0] rf_m [16];
  assign rf_src_data1 = rf_m[id_src_reg1];
  assign rf_src_data2 = rf_m[id_src_reg2];

  typedef struct {
    bit            valid;
    bit            done;
    logic [DW-1:0] alu, load, pc2;
    logic [AW-1:0] dst;
    bit            rw;
    logic [1:0]    sel;
    bit            halt;
  } instr_t;

  instr_t slot;
  bit     m_halted;
  int     m_count;
  int     checks = 0;
  int     failures = 0;
  bit     chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] result(input instr_t s);
    if (s.sel == 2'b01) return s.load;
    if (s.sel == 2'b10) return s.pc2;
    return s.alu;
  endfunction

  function automatic bit m_writes();
    return slot.valid && !slot.done && slot.rw && (slot.dst != 0);
  endfunction

  task automatic model_reset();
    slot = '{default: 0};
    m_halted = 0;
    m_count = 0;
  endtask

  // One clock edge at instruction level: the WB instruction retires once,
  // then the slot is refilled, kept, or emptied.
  task automatic model_edge();
    bit retiring;
    retiring = slot.valid && !slot.done;
    if (m_writes()) rf_m[slot.dst] = result(slot);
    if (retiring) begin
      if (m_count < 65535) m_count++;
      if (slot.halt) m_halted = 1;
    end
    if (flush || m_halted) slot.valid = 0;
    else if (stall) slot.done = slot.done || retiring;
    else begin
      slot.valid = mem_if.mem_valid;
      slot.done  = 0;
      slot.alu   = mem_if.mem_alu_result;
      slot.load  = mem_if.mem_load_data;
      slot.pc2   = mem_if.mem_pc_plus2;
      slot.dst   = mem_if.mem_dst_reg;
      slot.rw    = mem_if.mem_reg_write;
      slot.sel   = mem_if.mem_wb_sel;
      slot.halt  = mem_if.mem_halt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
  endtask

  task automatic set_instr(input bit v, input logic [DW-1:0] alu, input logic [DW-1:0] ld,
                           input logic [AW-1:0] dst, input bit rw, input logic [1:0] sel,
                           input bit hlt);
    mem_if.mem_valid      = v;
    mem_if.mem_alu_result = alu;
    mem_if.mem_load_data  = ld;
    mem_if.mem_pc_plus2   = alu ^ 16'h0F0F;
    mem_if.mem_dst_reg    = dst;
    mem_if.mem_reg_write  = rw;
    mem_if.mem_wb_sel     = sel;
    mem_if.mem_halt       = hlt;
  endtask

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic          exp_we;
      logic [DW-1:0] e1, e2;
      exp_we = m_writes();
      e1 = (exp_we && id_src_reg1 == slot.dst) ? result(slot) : rf_m[id_src_reg1];
      e2 = (exp_we && id_src_reg2 == slot.dst) ? result(slot) : rf_m[id_src_reg2];
      chk("wb_write_reg", {31'd0, wb_write_reg}, {31'd0, exp_we});
      if (exp_we) begin
        chk("wb_dst_reg", {28'd0, wb_dst_reg}, {28'd0, slot.dst});
        chk("wb_dst_data", {16'd0, wb_dst_data}, {16'd0, result(slot)});
      end
      chk("id_src_data1", {16'd0, id_src_data1}, {16'd0, e1});
      chk("id_src_data2", {16'd0, id_src_data2}, {16'd0, e2});
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("retired_count", {16'd0, retired_count}, m_count);
    end
  end

  int pulses;

  initial begin
    for (int r = 0; r < 16; r++) rf_m[r] = '0;
    stall = 0; flush = 0; id_src_reg1 = 0; id_src_reg2 = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    rst_n = 1;
    chk_en = 1;
    chk("rst wb_write_reg", {31'd0, wb_write_reg}, 0);
    chk("rst wb_dst_reg", {28'd0, wb_dst_reg}, 0);
    chk("rst wb_dst_data", {16'd0, wb_dst_data}, 0);
    chk("rst halted", {31'd0, halted}, 0);
    chk("rst retired_count", {16'd0, retired_count}, 0);

    // ALU write to R1, then the same to R0
    set_instr(1, 16'h2A59, 16'h0000, 4'd1, 1, 2'b00, 0);
    step();
    set_instr(1, 16'h2A59, 16'h0000, 4'd0, 1, 2'b00, 0);
    chk("alu we", {31'd0, wb_write_reg}, 1);
    chk("alu dst", {28'd0, wb_dst_reg}, 1);
    chk("alu data", {16'd0, wb_dst_data}, 32'h2A59);
    chk("alu count", {16'd0, retired_count}, 0);
    step();
    chk("r0 count", {16'd0, retired_count}, 1);
    chk("r0 we", {31'd0, wb_write_reg}, 0);

    // Load to R3 with bypass on port 2
    set_instr(1, 16'h1111, 16'hBEEF, 4'd3, 1, 2'b01, 0);
    id_src_reg2 = 4'd3;
    step();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("load count", {16'd0, retired_count}, 2);
    chk("load bypass", {16'd0, id_src_data2}, 32'hBEEF);
    step();
    #1;
    chk("bubble count", {16'd0, retired_count}, 3);
    chk("bubble we", {31'd0, wb_write_reg}, 0);
    chk("bubble rd2", {16'd0, id_src_data2}, {16'd0, rf_src_data2});
    chk("bubble rf", {16'd0, id_src_data2}, 32'hBEEF);

    // Load R5 held by a 3-cycle stall: one write, one retirement
    set_instr(1, 16'h0000, 16'h1234, 4'd5, 1, 2'b01, 0);
    step();
    stall = 1;
    set_instr(1, 16'hDEAD, 16'hDEAD, 4'd6, 1, 2'b00, 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      if (wb_write_reg) pulses++;
      step();
    end
    stall = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    if (wb_write_reg) pulses++;
    step();
    chk("stall pulses", pulses, 1);
    chk("stall count", {16'd0, retired_count}, 4);

    // Stall + flush together: write still issued, instruction dropped
    set_instr(1, 16'h5555, 16'h0000, 4'd6, 1, 2'b00, 0);
    step();
    stall = 1; flush = 1;
    chk("sf we", {31'd0, wb_write_reg}, 1);
    step();
    stall = 0; flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    chk("sf dropped", {31'd0, wb_write_reg}, 0);
    chk("sf count", {16'd0, retired_count}, 5);

    // HLT then ALU writes to R2 that must be ignored
    set_instr(1, 16'h0000, 16'h0000, 4'd0, 0, 2'b00, 1);
    step();
    set_instr(1, 16'h7777, 16'h0000, 4'd2, 1, 2'b00, 0);
    step();
    chk("hlt halted", {31'd0, halted}, 1);
    chk("hlt count", {16'd0, retired_count}, 6);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (wb_write_reg) pulses++;
      step();
    end
    chk("post-hlt pulses", pulses, 0);
    chk("post-hlt count", {16'd0, retired_count}, 6);

    // Asynchronous reset mid-cycle with a pending write
    rst_n = 0; model_reset(); #3; rst_n = 1;
    set_instr(1, 16'h9999, 16'h0000, 4'd4, 1, 2'b00, 0);
    step();
    chk("pre-rst we", {31'd0, wb_write_reg}, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst we", {31'd0, wb_write_reg}, 0);
    chk("arst dst", {28'd0, wb_dst_reg}, 0);
    chk("arst data", {16'd0, wb_dst_data}, 0);
    chk("arst halted", {31'd0, halted}, 0);
    chk("arst count", {16'd0, retired_count}, 0);
    model_reset();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Randomized traffic with periodic resets
    for (int i = 0; i < 3000; i++) begin
      set_instr($urandom_range(3) != 0, 16'($urandom), 16'($urandom), 4'($urandom_range(15)),
                $urandom_range(4) != 0, 2'($urandom_range(3)), $urandom_range(63) == 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(9) == 0);
      id_src_reg1 = 4'($urandom_range(15));
      id_src_reg2 = 4'($urandom_range(15));
      step();
      if (i % 250 == 249) begin
        rst_n = 0;
        model_reset();
        #6;
        rst_n = 1;
      end
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
